c499_enc_pipe: RTL and testbench
================================

C499_ENC_PIPE -- requirements
Module: c499_enc_pipe

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning:
  - clk, in, 1: single clock; all state changes on the rising edge.
  - rst_n, in, 1: asynchronous assert, active-low reset.
  - in_valid, in, 1: input word present.
  - in_ready, out, 1: block accepts the input word this cycle.
  - in_data, in, 32: data word; d[i] = in_data[i].
  - out_valid, out, 1: codeword present.
  - out_ready, in, 1: downstream accepts the codeword.
  - out_data, out, 32: data copy.
  - out_check, out, 8: check byte c[7:0].
  - word_cnt, out, 16: count of words delivered downstream.
REQ-002 The only parameter SHALL be DEPTH (default 2): the number of pipeline stages; legal values are 1 and 2.

Function
REQ-003 The block SHALL compute group parities g[k] = d[4k]^d[4k+1]^d[4k+2]^d[4k+3], for k = 0..7.
REQ-004 The block SHALL compute the check bits so that the companion 32-bit SEC corrector sees a zero syndrome:
  - c0 = g4^g5^d0^d4^d8^d12
  - c1 = g6^g7^d1^d5^d9^d13
  - c2 = g4^g6^d2^d6^d10^d14
  - c3 = g5^g7^d3^d7^d11^d15
  - c4 = g0^g1^d16^d20^d24^d28
  - c5 = g2^g3^d17^d21^d25^d29
  - c6 = g0^g2^d18^d22^d26^d30
  - c7 = g1^g3^d19^d23^d27^d31
REQ-005 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-006 The pipeline SHALL be DEPTH valid/data register stages:
  - Stage 1 registers in_data together with the eight column terms and the g[7:0] vector.
  - Stage 2 (present when DEPTH=2) registers out_data and out_check.
  - With DEPTH=1, out_check SHALL be formed in stage 1.
REQ-007 Latency SHALL be DEPTH cycles from an input transfer to out_valid when the pipeline is empty and there is no backpressure.
REQ-008 Each stage SHALL load when it is empty, or when its downstream stage is advancing in the same cycle.
REQ-009 in_ready SHALL be 1 when stage 1 can load; in_ready SHALL NOT depend combinationally on in_valid.
REQ-010 Sustained throughput SHALL be one word per cycle while out_ready=1.
REQ-011 While out_valid=1 and out_ready=0, out_data and out_check SHALL remain stable.
REQ-012 While out_valid=1 and out_ready=0, no word SHALL be dropped or duplicated.
REQ-013 Once a word is presented, out_valid SHALL NOT deassert until that word transfers.
REQ-014 A simultaneous input and output transfer with a full pipeline SHALL advance every stage by one position, with no bubble.
REQ-015 word_cnt SHALL increment by 1 on each output transfer.
REQ-016 word_cnt SHALL saturate at 0xFFFF and not wrap.
REQ-017 Words SHALL leave the block in the order they entered.

Reset
REQ-018 When rst_n=0, the block SHALL immediately force all valid flags, out_valid, in_ready, out_data, out_check and word_cnt to 0.
REQ-019 In-flight words SHALL be discarded on reset.
REQ-020 in_ready SHALL rise on the first rising edge after rst_n deasserts.
REQ-021 Reset asserted mid-transfer SHALL take precedence over any handshake in that cycle.

Configuration
REQ-022 When macro C499_KEYLOCK_EN is defined:
  - The block SHALL add input port key, width 8: a static locking key.
  - out_check SHALL equal c[7:0]^key, with key sampled with the data into stage 1.
REQ-023 When C499_KEYLOCK_EN is undefined, the key port SHALL be absent and out_check SHALL equal c[7:0].

Verification
REQ-024 The bench SHALL cover these directed scenarios (DEPTH=2, macro undefined unless stated); each line gives stimulus and the required response:
  - Check values:
    - in_data=0x00000001 -> out_check=0x51.
    - in_data=0x00000010 -> out_check=0x91.
    - in_data=0xFFFFFFFF -> out_check=0x00.
    - In each case out_valid rises exactly 2 cycles after acceptance.
  - Backpressure: 4 back-to-back words with out_ready=0 -> after 2 accepts in_ready=0 and the outputs stay stable; then with out_ready=1 -> all 4 words emerge in order at 1 per cycle, and word_cnt=4.
  - Reset mid-stream: rst_n pulsed low with 2 words in flight -> out_valid=0 and word_cnt=0 at once; no stale word appears after release.
  - Saturation: word_cnt preloaded by 65535 transfers, then 1 more transfer -> word_cnt=0xFFFF.
  - Key-lock (macro defined): key=0xA5, in_data=0x00000001 -> out_check=0xF4.
  - Zero syndrome: 10000 random words -> the encoder output fed into the companion corrector model returns a zero syndrome and unchanged data.

Source files
------------

// File: rtl/c499_enc_pipe.sv
// -----------------------------------------------------------------------------
// c499_enc_pipe -- pipelined check-byte encoder for a 32-bit SEC code.
//
// Each accepted 32-bit data word leaves the block with an 8-bit check byte
// chosen so that the companion single-error corrector computes a zero
// syndrome. Valid/ready handshakes on both sides; DEPTH register stages.
//
// Parameters:
//   DEPTH      number of pipeline stages, 1 or 2 (default 2)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   block accepts the input word this cycle
//   in_data    32-bit data word
//   out_valid  codeword present
//   out_ready  downstream accepts the codeword
//   out_data   data copy of the word
//   out_check  check byte (XORed with key when the key-lock option is built)
//   key        8-bit static locking key (only with C499_KEYLOCK_EN)
//   word_cnt   saturating count of words delivered downstream
//
// Build option:
//   C499_KEYLOCK_EN  adds the key port; out_check = c ^ key, key sampled
//                    together with the data into stage 1.
// -----------------------------------------------------------------------------
module c499_enc_pipe #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [7:0]  out_check,
`ifdef C499_KEYLOCK_EN
   input  logic [7:0]  key,
`endif
   output logic [15:0] word_cnt
);

   // Column terms: bit j (j<4) folds d[j], d[j+4], d[j+8], d[j+12] of the low
   // half; bit j+4 folds the same positions of the high half.
   function automatic logic [7:0] col_terms(input logic [31:0] d);
      logic [7:0] t;
      for (int j = 0; j < 4; j++) begin
         t[j]   = d[j]    ^ d[j+4]  ^ d[j+8]  ^ d[j+12];
         t[j+4] = d[j+16] ^ d[j+20] ^ d[j+24] ^ d[j+28];
      end
      return t;
   endfunction

   // Group parities: g[k] is the XOR of nibble k.
   function automatic logic [7:0] grp_par(input logic [31:0] d);
      logic [7:0] g;
      for (int k = 0; k < 8; k++) begin
         g[k] = ^d[4*k +: 4];
      end
      return g;
   endfunction

   // Combine column terms with pairs of group parities: the high-half
   // nibble parities protect the low-half checks and vice versa.
   function automatic logic [7:0] check_bits(input logic [7:0] col,
                                             input logic [7:0] g);
      logic [7:0] c;
      c[0] = g[4] ^ g[5] ^ col[0];
      c[1] = g[6] ^ g[7] ^ col[1];
      c[2] = g[4] ^ g[6] ^ col[2];
      c[3] = g[5] ^ g[7] ^ col[3];
      c[4] = g[0] ^ g[1] ^ col[4];
      c[5] = g[2] ^ g[3] ^ col[5];
      c[6] = g[0] ^ g[2] ^ col[6];
      c[7] = g[1] ^ g[3] ^ col[7];
      return c;
   endfunction

   logic        rdy_q;        // low during and until the first edge after reset
   logic        s1_load;      // stage 1 may capture this cycle
   logic        in_fire;
   logic        out_fire;
   logic        s1_valid_q;
   logic [31:0] s1_data_q;
   logic [7:0]  s1_col_q;
   logic [7:0]  s1_grp_q;
   logic [7:0]  s1_lock;      // key applied to the check byte (0 when unlocked)
   logic [7:0]  s1_check;
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // in_ready is a function of pipeline state and out_ready only, never of
   // in_valid, so upstream can safely wait on it.
   assign in_ready = rdy_q & s1_load;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;
   assign word_cnt = cnt_q;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
      end
   end

   // NOTE: the data flops are reset as well, because the outputs they drive
   // must read zero while reset is asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_col_q   <= '0;
         s1_grp_q   <= '0;
      end else if (s1_load) begin
         s1_valid_q <= in_fire;
         if (in_fire) begin
            s1_data_q <= in_data;
            s1_col_q  <= col_terms(in_data);
            s1_grp_q  <= grp_par(in_data);
         end
      end
   end

`ifdef C499_KEYLOCK_EN
   logic [7:0] s1_key_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_key_q <= '0;
      end else if (s1_load && in_fire) begin
         s1_key_q <= key;
      end
   end

   assign s1_lock = s1_key_q;
`else
   assign s1_lock = 8'h00;
`endif

   assign s1_check = check_bits(s1_col_q, s1_grp_q) ^ s1_lock;

   generate
      if (DEPTH == 1) begin : g_one_stage
         assign s1_load   = ~s1_valid_q | out_ready;
         assign out_valid = s1_valid_q;
         assign out_data  = s1_data_q;
         assign out_check = s1_check;
      end else begin : g_two_stage
         logic        s2_valid_q;
         logic [31:0] s2_data_q;
         logic [7:0]  s2_check_q;
         logic        s2_load;

         // A stage loads when empty or when its successor drains this cycle,
         // so a full pipeline advances in lock-step without a bubble.
         assign s2_load = ~s2_valid_q | out_ready;
         assign s1_load = ~s1_valid_q | s2_load;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid_q <= 1'b0;
               s2_data_q  <= '0;
               s2_check_q <= '0;
            end else if (s2_load) begin
               s2_valid_q <= s1_valid_q;
               if (s1_valid_q) begin
                  s2_data_q  <= s1_data_q;
                  s2_check_q <= s1_check;
               end
            end
         end

         assign out_valid = s2_valid_q;
         assign out_data  = s2_data_q;
         assign out_check = s2_check_q;
      end
   endgenerate

   // NOTE: the next-state value gets its default before any condition, so the
   // combinational block can never infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (out_fire && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_c499_enc_pipe.sv
// -----------------------------------------------------------------------------
// tb_c499_enc_pipe -- self-checking bench for c499_enc_pipe (DEPTH = 2).
//
// Directed steps in one initial block; a negedge monitor pushes the expected
// codeword on every input transfer and pops/compares on every output transfer,
// also running each delivered codeword through a SEC corrector model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_c499_enc_pipe;

`ifdef C499_KEYLOCK_EN
   localparam logic [7:0] KEY = 8'hA5;
`else
   localparam logic [7:0] KEY = 8'h00;
`endif

   typedef struct {
      logic [31:0] data;
      logic [7:0]  chk;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_check;
   logic [15:0] word_cnt;
`ifdef C499_KEYLOCK_EN
   logic [7:0]  key_r = KEY;
`endif

   int   tests = 0;
   int   fails = 0;
   int   n_out = 0;
   bit   rand_ready = 1'b0;
   exp_t sb[$];

   exp_t        mon_e;
   logic [39:0] mon_corr;
   logic [31:0] hold_d;
   logic [7:0]  hold_c;

   c499_enc_pipe #(.DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_check (out_check),
`ifdef C499_KEYLOCK_EN
      .key       (key_r),
`endif
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   // Reference check byte, written directly from the defining equations.
   function automatic logic [7:0] ref_check(input logic [31:0] d);
      logic [7:0] g;
      logic [7:0] c;
      for (int k = 0; k < 8; k++) g[k] = d[4*k] ^ d[4*k+1] ^ d[4*k+2] ^ d[4*k+3];
      c[0] = g[4] ^ g[5] ^ d[0]  ^ d[4]  ^ d[8]  ^ d[12];
      c[1] = g[6] ^ g[7] ^ d[1]  ^ d[5]  ^ d[9]  ^ d[13];
      c[2] = g[4] ^ g[6] ^ d[2]  ^ d[6]  ^ d[10] ^ d[14];
      c[3] = g[5] ^ g[7] ^ d[3]  ^ d[7]  ^ d[11] ^ d[15];
      c[4] = g[0] ^ g[1] ^ d[16] ^ d[20] ^ d[24] ^ d[28];
      c[5] = g[2] ^ g[3] ^ d[17] ^ d[21] ^ d[25] ^ d[29];
      c[6] = g[0] ^ g[2] ^ d[18] ^ d[22] ^ d[26] ^ d[30];
      c[7] = g[1] ^ g[3] ^ d[19] ^ d[23] ^ d[27] ^ d[31];
      return c;
   endfunction

   // Companion corrector: returns {syndrome, corrected data}.
   function automatic logic [39:0] correct(input logic [31:0] d, input logic [7:0] c);
      logic [7:0]  syn;
      logic [31:0] cd;
      syn = ref_check(d) ^ c ^ KEY;
      cd  = d;
      if (syn != 8'h00) begin
         for (int i = 0; i < 32; i++) begin
            if (ref_check(32'h1 << i) == syn) cd[i] = ~cd[i];
         end
      end
      return {syn, cd};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word and hold it until accepted (bounded).
   task automatic send(input logic [31:0] d);
      int budget;
      bit acc;
      budget   = 0;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         if (rand_ready) out_ready = ($urandom_range(0, 7) != 0);
         @(negedge clk);
         acc = in_ready;
         tick();
         budget++;
      end while (!acc && budget < 100);
      if (!acc) check("send_accept_timeout", 32'(acc), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (sb.size() != 0 && budget < 200) begin
         tick();
         budget++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   // Single word into an empty pipeline: out_valid must appear 2 cycles later.
   task automatic send_timed(input logic [31:0] d, input logic [7:0] expc, input string tag);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1_idle"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_check"}, 32'(out_check), 32'(expc));
      check({tag, "_data"}, out_data, d);
      tick();
   endtask

   // Scoreboard monitor: handshakes are stable at the falling edge, so a
   // transfer seen here happens on the following rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               check("out_data", out_data, mon_e.data);
               check("out_check", 32'(out_check), 32'(mon_e.chk));
               mon_corr = correct(out_data, out_check);
               check("syndrome", 32'(mon_corr[39:32]), 32'd0);
               check("corrected", mon_corr[31:0], mon_e.data);
            end
            n_out++;
         end
         if (in_valid && in_ready) begin
            sb.push_back('{data: in_data, chk: ref_check(in_data) ^ KEY});
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  out_data,       32'd0);
      check("rst_out_check", 32'(out_check), 32'd0);
      check("rst_word_cnt",  32'(word_cnt),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      check("rel_in_ready_rise", 32'(in_ready), 32'd1);

      // Backpressure: two words fill the pipe, the rest wait
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h1234_5678;
      tick();
      in_data   = 32'hDEAD_BEEF;
      tick();
      in_data   = 32'h0F0F_00FF;
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_head_data", out_data, 32'h1234_5678);
      hold_d = out_data;
      hold_c = out_check;
      repeat (3) begin
         tick();
         check("bp_valid_held", 32'(out_valid), 32'd1);
         check("bp_data_stable", out_data, hold_d);
         check("bp_check_stable", 32'(out_check), 32'(hold_c));
      end
      out_ready = 1'b1;
      check("bp_flow0", 32'(out_valid), 32'd1);
      tick();
      in_data = 32'h8000_0001;
      check("bp_flow1", 32'(out_valid), 32'd1);
      tick();
      in_valid = 1'b0;
      check("bp_flow2", 32'(out_valid), 32'd1);
      tick();
      check("bp_flow3", 32'(out_valid), 32'd1);
      tick();
      check("bp_empty", 32'(out_valid), 32'd0);
      check("bp_word_cnt", 32'(word_cnt), 32'd4);
      check("bp_sb_empty", 32'(sb.size()), 32'd0);

      // Check values and two-cycle latency
      send_timed(32'h0000_0001, 8'h51 ^ KEY, "cv_01");
      send_timed(32'h0000_0010, 8'h91 ^ KEY, "cv_10");
      send_timed(32'hFFFF_FFFF, 8'h00 ^ KEY, "cv_ff");
      check("cv_word_cnt", 32'(word_cnt), 32'd7);

      // Reset mid-stream with two words in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hCAFE_0001;
      tick();
      in_data   = 32'hCAFE_0002;
      tick();
      in_valid  = 1'b0;
      check("mid_full", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_out_valid", 32'(out_valid), 32'd0);
      check("mid_word_cnt",  32'(word_cnt),  32'd0);
      check("mid_in_ready",  32'(in_ready),  32'd0);
      check("mid_out_data",  out_data,       32'd0);
      check("mid_out_check", 32'(out_check), 32'd0);
      sb.delete();
      n_out = 0;
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("mid_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      check("mid_in_ready_rise", 32'(in_ready), 32'd1);
      repeat (4) begin
         check("mid_no_stale", 32'(out_valid), 32'd0);
         tick();
      end

      // Random words under random backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 10000; i++) send($urandom());
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();
      check("rand_word_cnt", 32'(word_cnt), 32'd10000);

      // Saturation: bring the count to 0xFFFF, then one more transfer
      while (n_out + sb.size() < 65535) send($urandom());
      drain();
      check("sat_reach", 32'(word_cnt), 32'h0000_FFFF);
      send(32'hA5A5_5A5A);
      drain();
      check("sat_hold", 32'(word_cnt), 32'h0000_FFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
